// File: rtl/tm1638_responder_pkg.sv
// ============================================================================
// Module : tm1638_responder_pkg
// Brief  : Command field codes, bit positions and FSM states for the responder
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tm1638_responder_pkg;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_CTRL = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    localparam int READ_BIT    = 1;
    localparam int FIXED_BIT   = 2;
    localparam int DISP_ON_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WDATA  = 3'd2,
        ST_RDATA  = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tm1638_responder_if.sv
// ============================================================================
// Module : tm1638_responder_if
// Brief  : TM1638 3-wire link (STB/CLK/DIO split into in/out/oe) with modports
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface tm1638_responder_if;
    logic tm1638_strobe;
    logic tm1638_clk;
    logic tm1638_data;
    logic dio_out;
    logic dio_oe;

    modport master (
        output tm1638_strobe, tm1638_clk, tm1638_data,
        input  dio_out, dio_oe
    );

    modport slave (
        input  tm1638_strobe, tm1638_clk, tm1638_data,
        output dio_out, dio_oe
    );
endinterface

`default_nettype wire

// File: rtl/tm1638_in_sync.sv
// ============================================================================
// Module : tm1638_in_sync
// Brief  : Synchronizes STB/CLK/DIO into clk domain; edge detect on STB and CLK
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tm1638_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire  clk,
    input  wire  n_rst,
    input  wire  strobe_i,
    input  wire  sclk_i,
    input  wire  data_i,
    output logic strobe_rise_o,
    output logic strobe_fall_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic data_o
);

    logic [SYNC_STAGES-1:0] stb_q;
    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] data_q;
    logic                   stb_prev_q;
    logic                   sclk_prev_q;

    // STB resets low so a strobe held low through reset release is not a frame start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stb_q       <= '0;
            sclk_q      <= '1;
            data_q      <= '1;
            stb_prev_q  <= 1'b0;
            sclk_prev_q <= 1'b1;
        end else begin
            stb_q       <= {stb_q[SYNC_STAGES-2:0], strobe_i};
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            data_q      <= {data_q[SYNC_STAGES-2:0], data_i};
            stb_prev_q  <= stb_q[SYNC_STAGES-1];
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign strobe_rise_o = stb_q[SYNC_STAGES-1] & ~stb_prev_q;
    assign strobe_fall_o = ~stb_q[SYNC_STAGES-1] & stb_prev_q;
    assign sclk_rise_o   = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall_o   = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;
    assign data_o        = data_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/tm1638_responder.sv
// ============================================================================
// Module : tm1638_responder
// Brief  : TM1638 device-side responder: display RAM, control regs, key readback.
//          Optional counters frame_cnt/err_cnt when TM1638_RSP_STATS_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tm1638_responder
    import tm1638_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RAM_DEPTH   = 16,
    parameter int KEY_BYTES   = 4
) (
    input  wire                     clk,
    input  wire                     n_rst,
    tm1638_responder_if.slave       bus,
    input  wire  [8*KEY_BYTES-1:0]  key_scan,
    input  wire  [3:0]              disp_raddr,
    output logic [7:0]              disp_rdata,
    output logic                    display_on,
    output logic [2:0]              brightness,
    output logic                    ram_wr_pulse,
`ifdef TM1638_RSP_STATS_EN
    output logic [15:0]             frame_cnt,
    output logic [7:0]              err_cnt,
`endif
    output logic                    cmd_err
);

    logic stb_rise, stb_fall, sclk_rise, sclk_fall, data_s;

    tm1638_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk           (clk),
        .n_rst         (n_rst),
        .strobe_i      (bus.tm1638_strobe),
        .sclk_i        (bus.tm1638_clk),
        .data_i        (bus.tm1638_data),
        .strobe_rise_o (stb_rise),
        .strobe_fall_o (stb_fall),
        .sclk_rise_o   (sclk_rise),
        .sclk_fall_o   (sclk_fall),
        .data_o        (data_s)
    );

    state_t                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [3:0]             addr_q, addr_d;
    logic                   fixed_q, fixed_d;
    logic [8*KEY_BYTES-1:0] keys_q, keys_d;
    logic                   oe_q, oe_d;
    logic                   disp_on_q, disp_on_d;
    logic [2:0]             bright_q, bright_d;
    logic                   wr_pulse_q, wr_en;
    logic                   err_q, err_d;
    logic [7:0]             ram_q [RAM_DEPTH];
    logic [7:0]             byte_w;

    // Incoming bit lands in the MSB; after eight rises byte_w holds the LSB-first byte.
    assign byte_w = {data_s, shift_q};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        fixed_d   = fixed_q;
        keys_d    = keys_q;
        oe_d      = oe_q;
        disp_on_d = disp_on_q;
        bright_d  = bright_q;
        wr_en     = 1'b0;
        err_d     = 1'b0;
        if (stb_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            err_d     = ((state_q == ST_CMD) || (state_q == ST_WDATA)) && (bit_cnt_q != 3'd0);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stb_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                    end
                end
                ST_CMD, ST_WDATA: begin
                    if (sclk_rise) begin
                        shift_d   = byte_w[7:1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_WDATA) begin
                                wr_en = 1'b1;
                                if (!fixed_q) addr_d = addr_q + 4'd1;
                            end else begin
                                case (byte_w[7:6])
                                    CMD_DATA: begin
                                        // Direction acts on this frame directly; only the
                                        // addressing mode needs to outlive it.
                                        fixed_d = byte_w[FIXED_BIT];
                                        if (byte_w[READ_BIT]) begin
                                            keys_d  = key_scan;
                                            oe_d    = 1'b0;
                                            state_d = ST_RDATA;
                                        end else begin
                                            state_d = ST_IGNORE;
                                        end
                                    end
                                    CMD_CTRL: begin
                                        disp_on_d = byte_w[DISP_ON_BIT];
                                        bright_d  = byte_w[2:0];
                                        state_d   = ST_IGNORE;
                                    end
                                    CMD_ADDR: begin
                                        addr_d  = byte_w[3:0];
                                        state_d = ST_WDATA;
                                    end
                                    default: begin
                                        err_d   = 1'b1;
                                        state_d = ST_IGNORE;
                                    end
                                endcase
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        if (!oe_q) oe_d   = 1'b1;
                        else       keys_d = keys_q >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            fixed_q    <= 1'b0;
            keys_q     <= '0;
            oe_q       <= 1'b0;
            disp_on_q  <= 1'b0;
            bright_q   <= '0;
            wr_pulse_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            fixed_q    <= fixed_d;
            keys_q     <= keys_d;
            oe_q       <= oe_d;
            disp_on_q  <= disp_on_d;
            bright_q   <= bright_d;
            wr_pulse_q <= wr_en;
            err_q      <= err_d;
            if (wr_en) ram_q[addr_q] <= byte_w;
        end
    end

    // Output enable drops combinationally on the synced STB rise.
    assign bus.dio_oe  = oe_q & ~stb_rise;
    assign bus.dio_out = bus.dio_oe ? keys_q[0] : 1'b1;

    assign disp_rdata   = ram_q[disp_raddr];
    assign display_on   = disp_on_q;
    assign brightness   = bright_q;
    assign ram_wr_pulse = wr_pulse_q;
    assign cmd_err      = err_q;

`ifdef TM1638_RSP_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (stb_rise) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (err_d && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tm1638_responder.sv
// ============================================================================
// Module : tb_tm1638_responder
// Brief  : Self-checking bench for tm1638_responder against a byte-level model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tm1638_responder;

    localparam int SYNC = 2;
    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [31:0] key_scan;
    logic [3:0]  disp_raddr;
    logic [7:0]  disp_rdata;
    logic        display_on;
    logic [2:0]  brightness;
    logic        ram_wr_pulse;
    logic        cmd_err;
`ifdef TM1638_RSP_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    tm1638_responder_if bus ();

    tm1638_responder #(.SYNC_STAGES(SYNC), .RAM_DEPTH(16), .KEY_BYTES(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .bus          (bus),
        .key_scan     (key_scan),
        .disp_raddr   (disp_raddr),
        .disp_rdata   (disp_rdata),
        .display_on   (display_on),
        .brightness   (brightness),
        .ram_wr_pulse (ram_wr_pulse),
`ifdef TM1638_RSP_STATS_EN
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt),
`endif
        .cmd_err      (cmd_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_pulses = 0;
    int err_pulses = 0;

    logic [7:0] m_ram [16];
    logic       m_on;
    logic [2:0] m_bri;
    logic       m_fixed;

    always @(negedge clk) begin
        if (ram_wr_pulse === 1'b1) wr_pulses++;
        if (cmd_err === 1'b1) err_pulses++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic stb_start();
        bus.tm1638_strobe = 1'b0;
        cyc(2 * HALF);
    endtask

    task automatic stb_end();
        bus.tm1638_strobe = 1'b1;
        cyc(2 * HALF + SYNC + 2);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            bus.tm1638_clk  = 1'b0;
            bus.tm1638_data = b[i];
            cyc(HALF);
            bus.tm1638_clk  = 1'b1;
            cyc(HALF);
        end
    endtask

    task automatic read_byte(output logic [7:0] b, output logic oe_ok);
        oe_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.tm1638_clk = 1'b0;
            cyc(HALF);
            b[i] = bus.dio_out;
            if (bus.dio_oe !== 1'b1) oe_ok = 1'b0;
            bus.tm1638_clk = 1'b1;
            cyc(HALF);
        end
    endtask

    // Single-byte command frame; the model applies the command's meaning.
    task automatic cmd_frame(input logic [7:0] c);
        stb_start();
        send_bits(c, 8);
        stb_end();
        if (c[7:6] == 2'b01) m_fixed = c[2];
        if (c[7:6] == 2'b10) begin
            m_on  = c[3];
            m_bri = c[2:0];
        end
    endtask

    task automatic write_burst(input logic [3:0] a0, input int n);
        logic [3:0] a;
        logic [7:0] d;
        a = a0;
        stb_start();
        send_bits({4'hC, a0}, 8);
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            send_bits(d, 8);
            m_ram[a] = d;
            if (!m_fixed) a = a + 4'd1;
        end
        stb_end();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        bus.tm1638_strobe = 1'b1;
        bus.tm1638_clk    = 1'b1;
        bus.tm1638_data   = 1'b1;
        key_scan   = '0;
        disp_raddr = '0;
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_on = 1'b0; m_bri = 3'd0; m_fixed = 1'b0;
        cyc(3);
        n_cmp++;
        if (bus.dio_oe !== 1'b0 || bus.dio_out !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_dio: oe=%b out=%b, expected oe=0 out=1", bus.dio_oe, bus.dio_out);
        end
        n_rst = 1'b1;
        cyc(SYNC + 4);
        n_cmp++;
        if (display_on !== 1'b0 || brightness !== 3'd0 || ram_wr_pulse !== 1'b0 || cmd_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outs: on=%b bri=%0d wr=%b err=%b, expected 0 0 0 0",
                     display_on, brightness, ram_wr_pulse, cmd_err);
        end
        for (int i = 0; i < 16; i++) begin
            disp_raddr = 4'(i); #1;
            n_cmp++;
            if (disp_rdata !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_ram[%0d]: got %h, expected 00", i, disp_rdata);
            end
        end
    endtask

    task automatic test_auto_inc();
        int w0;
        cmd_frame(8'h40);
        w0 = wr_pulses;
        write_burst(4'd0, 3);
        n_cmp++;
        if (wr_pulses - w0 != 3) begin
            n_bad++;
            $display("FAIL auto_inc_pulses: got %0d, expected 3", wr_pulses - w0);
        end
        for (int i = 0; i < 16; i++) begin
            disp_raddr = 4'(i); #1;
            n_cmp++;
            if (disp_rdata !== m_ram[i]) begin
                n_bad++;
                $display("FAIL auto_inc_ram[%0d]: got %h, expected %h", i, disp_rdata, m_ram[i]);
            end
        end
    endtask

    task automatic test_fixed_and_wrap();
        cmd_frame(8'h44);
        write_burst(4'd5, 2);
        cmd_frame(8'h40);
        write_burst(4'd15, 2);
        for (int i = 0; i < 16; i++) begin
            disp_raddr = 4'(i); #1;
            n_cmp++;
            if (disp_rdata !== m_ram[i]) begin
                n_bad++;
                $display("FAIL fixed_wrap_ram[%0d]: got %h, expected %h", i, disp_rdata, m_ram[i]);
            end
        end
    endtask

    task automatic test_read();
        logic [31:0] snap;
        logic [7:0]  b;
        logic        ok;
        for (int it = 0; it < 2; it++) begin
            snap = (it == 0) ? 32'h8040_2001 : $urandom;
            key_scan = snap;
            stb_start();
            send_bits(8'h42, 8);
            m_fixed = 1'b0;
            key_scan = $urandom;
            n_cmp++;
            if (bus.dio_oe !== 1'b0) begin
                n_bad++;
                $display("FAIL read_oe_before: got %b, expected 0", bus.dio_oe);
            end
            for (int k = 0; k < 5; k++) begin
                read_byte(b, ok);
                n_cmp++;
                if (b !== ((k < 4) ? snap[8*k +: 8] : 8'h00) || !ok) begin
                    n_bad++;
                    $display("FAIL read_byte%0d: got %h oe_ok=%b, expected %h oe_ok=1",
                             k, b, ok, (k < 4) ? snap[8*k +: 8] : 8'h00);
                end
            end
            bus.tm1638_strobe = 1'b1;
            cyc(SYNC + 1);
            n_cmp++;
            if (bus.dio_oe !== 1'b0 || bus.dio_out !== 1'b1) begin
                n_bad++;
                $display("FAIL read_oe_release: oe=%b out=%b, expected 0 1", bus.dio_oe, bus.dio_out);
            end
            cyc(2 * HALF);
        end
        // Mode left at read: a write frame still lands in RAM.
        write_burst(4'd3, 1);
        disp_raddr = 4'd3; #1;
        n_cmp++;
        if (disp_rdata !== m_ram[3]) begin
            n_bad++;
            $display("FAIL write_after_read: got %h, expected %h", disp_rdata, m_ram[3]);
        end
    endtask

    task automatic test_ctrl();
        int e0, w0;
        logic [7:0] c;
        cmd_frame(8'h8A);
        n_cmp++;
        if (display_on !== 1'b1 || brightness !== 3'd2) begin
            n_bad++;
            $display("FAIL ctrl_8A: on=%b bri=%0d, expected 1 2", display_on, brightness);
        end
        for (int i = 0; i < 3; i++) begin
            c = {4'b1000, 4'($urandom)};
            cmd_frame(c);
            n_cmp++;
            if (display_on !== m_on || brightness !== m_bri) begin
                n_bad++;
                $display("FAIL ctrl_rand %h: on=%b bri=%0d, expected %b %0d", c, display_on, brightness, m_on, m_bri);
            end
        end
        e0 = err_pulses; w0 = wr_pulses;
        cmd_frame(8'h15);
        n_cmp++;
        if (err_pulses - e0 != 1 || wr_pulses != w0 || display_on !== m_on || brightness !== m_bri) begin
            n_bad++;
            $display("FAIL bad_cmd: errs=%0d wr=%0d on=%b bri=%0d, expected 1 0 %b %0d",
                     err_pulses - e0, wr_pulses - w0, display_on, brightness, m_on, m_bri);
        end
    endtask

    task automatic test_partial();
        int e0, w0;
        cmd_frame(8'h40);
        e0 = err_pulses; w0 = wr_pulses;
        stb_start();
        send_bits(8'hC0, 8);
        send_bits(8'($urandom), 5);
        stb_end();
        disp_raddr = 4'd0; #1;
        n_cmp++;
        if (err_pulses - e0 != 1 || wr_pulses != w0 || disp_rdata !== m_ram[0]) begin
            n_bad++;
            $display("FAIL partial_write: errs=%0d wr=%0d ram0=%h, expected 1 0 %h",
                     err_pulses - e0, wr_pulses - w0, disp_rdata, m_ram[0]);
        end
        e0 = err_pulses;
        stb_start();
        send_bits(8'h42, 8);
        send_bits(8'h00, 3);
        stb_end();
        m_fixed = 1'b0;
        n_cmp++;
        if (err_pulses != e0) begin
            n_bad++;
            $display("FAIL partial_read: errs=%0d, expected 0", err_pulses - e0);
        end
    endtask

    task automatic test_reset_mid();
        stb_start();
        send_bits(8'hC0, 8);
        send_bits(8'($urandom), 8);
        send_bits(8'($urandom), 3);
        n_rst = 1'b0;
        cyc(2);
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_on = 1'b0; m_bri = 3'd0; m_fixed = 1'b0;
        n_cmp++;
        if (display_on !== 1'b0 || brightness !== 3'd0 || bus.dio_oe !== 1'b0 || bus.dio_out !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_outs: on=%b bri=%0d oe=%b out=%b, expected 0 0 0 1",
                     display_on, brightness, bus.dio_oe, bus.dio_out);
        end
        for (int i = 0; i < 16; i++) begin
            disp_raddr = 4'(i); #1;
            n_cmp++;
            if (disp_rdata !== 8'h00) begin
                n_bad++;
                $display("FAIL mid_reset_ram[%0d]: got %h, expected 00", i, disp_rdata);
            end
        end
        // STB still low at release: this command must be ignored.
        n_rst = 1'b1;
        cyc(SYNC + 4);
        send_bits(8'h8F, 8);
        cyc(4);
        n_cmp++;
        if (display_on !== 1'b0) begin
            n_bad++;
            $display("FAIL stb_low_release: on=%b, expected 0", display_on);
        end
        stb_end();
        cmd_frame(8'h8F);
        n_cmp++;
        if (display_on !== 1'b1 || brightness !== 3'd7) begin
            n_bad++;
            $display("FAIL after_release_ctrl: on=%b bri=%0d, expected 1 7", display_on, brightness);
        end
    endtask

    task automatic test_random_writes();
        logic fx;
        for (int it = 0; it < 6; it++) begin
            fx = 1'($urandom);
            cmd_frame({5'b01000, fx, 2'b00});
            write_burst(4'($urandom), int'($urandom_range(1, 6)));
        end
        for (int i = 0; i < 16; i++) begin
            disp_raddr = 4'(i); #1;
            n_cmp++;
            if (disp_rdata !== m_ram[i]) begin
                n_bad++;
                $display("FAIL random_ram[%0d]: got %h, expected %h", i, disp_rdata, m_ram[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto_inc();
        test_fixed_and_wrap();
        test_read();
        test_ctrl();
        test_partial();
        test_random_writes();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
